// File: rtl/alarm_sched_pkg.sv
// Shared types, key codes and helpers for the alarm/chime scheduler.
// Optional hourly chime is built when ALARM_SCHED_CHIME_EN is defined.
package alarm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    PLAY,
    SNOOZE,
    LOCKOUT
  } state_t;

  localparam logic [3:0] KEY_SNOOZE = 4'd11;
  localparam logic [3:0] KEY_CANCEL = 4'd0;

  localparam int unsigned TO_W = 29;

  // BCD 24 h hour -> binary 12 h hour (00 -> 12, 13 -> 1, 12 -> 12)
  function automatic logic [15:0] bcd_hour_to_12h(input logic [7:0] bcd);
    logic [7:0] h;
    h = ({4'd0, bcd[7:4]} * 8'd10) + {4'd0, bcd[3:0]};
    if (h == 8'd0)
      return 16'd12;
    else if (h > 8'd12)
      return {8'd0, h - 8'd12};
    else
      return {8'd0, h};
  endfunction

endpackage

// File: rtl/alarm_sched_if.sv
// Buzzer-side handshake of the alarm scheduler: song request/ack and chime.
interface alarm_sched_if;
  logic        clock_en;
  logic        clock_ack;
  logic        beep_flag;
  logic [15:0] max_beep_times;

  modport master (
    output clock_en,
    output beep_flag,
    output max_beep_times,
    input  clock_ack
  );

  modport slave (
    input  clock_en,
    input  beep_flag,
    input  max_beep_times,
    output clock_ack
  );
endinterface

// File: rtl/alarm_sched_time_tick_det.sv
// Time-event detector: registers the live BCD time, flags minute changes,
// the alarm match rising edge and (with ALARM_SCHED_CHIME_EN) hour rollover.
module time_tick_det
  import alarm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] i_now_time,
  input  logic [15:0] i_alarm_time,
  input  logic        i_alarm_arm,
  output logic        o_min_tick,
  output logic        o_match_edge
`ifdef ALARM_SCHED_CHIME_EN
  ,
  output logic        o_hour_roll,
  output logic [7:0]  o_hour
`endif
);

  logic       w_match;
  logic [7:0] w_min_prev;
  logic       r_match;
  logic       r_match_d;

  assign w_match      = i_alarm_arm && (i_now_time[23:8] == i_alarm_time) &&
                        (i_now_time[7:0] == 8'h00);
  assign o_min_tick   = (i_now_time[15:8] != w_min_prev);
  assign o_match_edge = r_match && !r_match_d;

  // match history: one event per minute of equality
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_match   <= 1'b0;
      r_match_d <= 1'b0;
    end else begin
      r_match   <= w_match;
      r_match_d <= r_match;
    end
  end

`ifdef ALARM_SCHED_CHIME_EN
  logic [15:0] r_mmss;
  logic [7:0]  r_hour;
  logic        r_hour_roll;

  // Roll is registered once so it lines up with the match edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mmss      <= '0;
      r_hour      <= '0;
      r_hour_roll <= 1'b0;
    end else begin
      r_mmss      <= i_now_time[15:0];
      r_hour      <= i_now_time[23:16];
      r_hour_roll <= (i_now_time[15:0] == 16'h0000) && (r_mmss != 16'h0000);
    end
  end

  assign w_min_prev  = r_mmss[15:8];
  assign o_hour_roll = r_hour_roll;
  assign o_hour      = r_hour;
`else
  logic [7:0] r_min;

  // registered minute copy for tick detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_min <= '0;
    else     r_min <= i_now_time[15:8];
  end

  assign w_min_prev = r_min;
`endif

endmodule

// File: rtl/alarm_sched.sv
// Alarm scheduler top: starts songs on alarm match with repeat, snooze,
// cancel and ack timeout. Hourly chime is built with ALARM_SCHED_CHIME_EN.
module alarm_sched
  import alarm_pkg::*;
#(
  parameter int unsigned RING_REPEAT = 3,
  parameter int unsigned SNOOZE_MIN  = 5,
  parameter int unsigned ACK_TIMEOUT = 480_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [23:0]   now_time,
  input  logic [15:0]   alarm_time,
  input  logic          alarm_arm,
  input  logic          key_valid,
  input  logic [3:0]    key_value,
  alarm_sched_if.master bus,
  output logic          ringing
);

  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [3:0]      REP_LAST = 4'(RING_REPEAT);
  localparam logic [5:0]      SNZ_LAST = 6'(SNOOZE_MIN - 1);
  localparam logic [5:0]      SNZ_FULL = 6'(SNOOZE_MIN);

  logic w_min_tick;
  logic w_match_edge;
  logic w_ack_rise;
  logic w_cancel;
  logic w_snooze;

  state_t          r_state;
  logic [3:0]      r_rep;
  logic [5:0]      r_snz;
  logic [TO_W-1:0] r_to;
  logic            r_clock_en;
  logic            r_ringing;
  logic            r_ack_s1;
  logic            r_ack_s2;
  logic            r_ack_s3;

`ifdef ALARM_SCHED_CHIME_EN
  logic       w_hour_roll;
  logic [7:0] w_hour;
`endif

  time_tick_det u_tick (
    .clk          (clk),
    .rst          (rst),
    .i_now_time   (now_time),
    .i_alarm_time (alarm_time),
    .i_alarm_arm  (alarm_arm),
    .o_min_tick   (w_min_tick),
    .o_match_edge (w_match_edge)
`ifdef ALARM_SCHED_CHIME_EN
    ,
    .o_hour_roll  (w_hour_roll),
    .o_hour       (w_hour)
`endif
  );

  assign w_cancel   = key_valid && (key_value == KEY_CANCEL);
  assign w_snooze   = key_valid && (key_value == KEY_SNOOZE);
  assign w_ack_rise = r_ack_s2 && !r_ack_s3;

  // two-stage ack synchroniser plus edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack_s1 <= 1'b0;
      r_ack_s2 <= 1'b0;
      r_ack_s3 <= 1'b0;
    end else begin
      r_ack_s1 <= bus.clock_ack;
      r_ack_s2 <= r_ack_s1;
      r_ack_s3 <= r_ack_s2;
    end
  end

  // Ring FSM; clock_en/ringing are set with the transition into the state
  // that owns them, so both are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rep      <= '0;
      r_snz      <= '0;
      r_to       <= '0;
      r_clock_en <= 1'b0;
      r_ringing  <= 1'b0;
    end else begin
      r_clock_en <= 1'b0;
      if (!alarm_arm) begin
        r_state   <= IDLE;
        r_rep     <= '0;
        r_snz     <= '0;
        r_to      <= '0;
        r_ringing <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_match_edge) begin
              r_state    <= START;
              r_rep      <= '0;
              r_clock_en <= 1'b1;
              r_ringing  <= 1'b1;
            end
          end
          START, PLAY: begin
            if (w_cancel) begin
              r_state   <= LOCKOUT;
              r_ringing <= 1'b0;
            end else if (w_snooze) begin
              r_state <= SNOOZE;
              r_snz   <= '0;
            end else if (r_state == START) begin
              r_state <= PLAY;
              r_to    <= '0;
            end else if (w_ack_rise || (r_to == TO_LAST)) begin
              r_rep <= r_rep + 4'd1;
              if (r_rep + 4'd1 == REP_LAST) begin
                r_state   <= LOCKOUT;
                r_ringing <= 1'b0;
              end else begin
                r_state    <= START;
                r_clock_en <= 1'b1;
              end
            end else begin
              r_to <= r_to + 1'b1;
            end
          end
          SNOOZE: begin
            if (w_cancel) begin
              r_state   <= LOCKOUT;
              r_ringing <= 1'b0;
            end else if (w_min_tick) begin
              if (r_snz == SNZ_LAST) begin
                r_snz      <= SNZ_FULL;
                r_state    <= START;
                r_rep      <= '0;
                r_clock_en <= 1'b1;
              end else begin
                r_snz <= r_snz + 6'd1;
              end
            end
          end
          LOCKOUT: begin
            if (now_time[23:8] != alarm_time) begin
              r_state <= IDLE;
              r_rep   <= '0;
              r_snz   <= '0;
              r_to    <= '0;
            end
          end
          default: begin
            r_state   <= IDLE;
            r_ringing <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.clock_en = r_clock_en;
  assign ringing      = r_ringing;

`ifdef ALARM_SCHED_CHIME_EN
  logic        r_beep;
  logic [15:0] r_max_beep;

  // hourly chime, only while not ringing; a coincident alarm edge wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beep     <= 1'b0;
      r_max_beep <= '0;
    end else begin
      r_beep <= 1'b0;
      if (w_hour_roll && !w_match_edge &&
          ((r_state == IDLE) || (r_state == LOCKOUT))) begin
        r_beep     <= 1'b1;
        r_max_beep <= bcd_hour_to_12h(w_hour);
      end
    end
  end

  assign bus.beep_flag      = r_beep;
  assign bus.max_beep_times = r_max_beep;
`else
  assign bus.beep_flag      = 1'b0;
  assign bus.max_beep_times = '0;
`endif

endmodule

// File: tb/tb_alarm_sched.sv
// Directed bench for alarm_sched (ACK_TIMEOUT shortened to 1000 cycles).
// Chime expectations follow ALARM_SCHED_CHIME_EN.
module tb_alarm_sched;
  import alarm_pkg::*;

  logic        clk;
  logic        rst;
  logic [23:0] now_time;
  logic [15:0] alarm_time;
  logic        alarm_arm;
  logic        key_valid;
  logic [3:0]  key_value;
  logic        ringing;

  alarm_sched_if bus ();

  alarm_sched #(
    .RING_REPEAT (3),
    .SNOOZE_MIN  (5),
    .ACK_TIMEOUT (1000)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .now_time   (now_time),
    .alarm_time (alarm_time),
    .alarm_arm  (alarm_arm),
    .key_valid  (key_valid),
    .key_value  (key_value),
    .bus        (bus),
    .ringing    (ringing)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [23:0] now;
    logic [15:0] alm;
    logic        exp_ce;
    logic        exp_ring;
    logic        exp_beep;
    logic [15:0] exp_max;
  } vec_t;

  vec_t v_main  [4];
  vec_t v_chime [15];

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    logic        eb;
    logic [15:0] em;
    now_time   = v.now;
    alarm_time = v.alm;
    tick();
`ifdef ALARM_SCHED_CHIME_EN
    eb = v.exp_beep;
    em = v.exp_max;
`else
    eb = 1'b0;
    em = 16'd0;
`endif
    chk($sformatf("%s.ce", nm),   32'(bus.clock_en),       32'(v.exp_ce));
    chk($sformatf("%s.ring", nm), 32'(ringing),            32'(v.exp_ring));
    chk($sformatf("%s.beep", nm), 32'(bus.beep_flag),      32'(eb));
    chk($sformatf("%s.max", nm),  32'(bus.max_beep_times), 32'(em));
  endtask

  task automatic count_ce(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.clock_en) c++;
    end
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_value = k;
    tick();
    key_valid = 1'b0;
  endtask

  // ack rises; the next request (or lockout) is seen 3 cycles later
  task automatic ack_expect(input string nm, input logic restart);
    bus.clock_ack = 1'b1;
    tick();
    chk($sformatf("%s.t1", nm), 32'(bus.clock_en), 32'd0);
    bus.clock_ack = 1'b0;
    tick();
    chk($sformatf("%s.t2", nm), 32'(bus.clock_en), 32'd0);
    tick();
    chk($sformatf("%s.ce", nm),   32'(bus.clock_en), 32'(restart));
    chk($sformatf("%s.ring", nm), 32'(ringing),      32'(restart));
  endtask

  initial begin
    int c;
    int n;

    rst           = 1'b1;
    now_time      = '0;
    alarm_time    = '0;
    alarm_arm     = 1'b0;
    key_valid     = 1'b0;
    key_value     = '0;
    bus.clock_ack = 1'b0;

    v_main[0] = '{24'h072959, 16'h0730, 1'b0, 1'b0, 1'b0, 16'd0};
    v_main[1] = '{24'h073000, 16'h0730, 1'b0, 1'b0, 1'b0, 16'd0};
    v_main[2] = '{24'h073000, 16'h0730, 1'b1, 1'b1, 1'b0, 16'd0};
    v_main[3] = '{24'h073000, 16'h0730, 1'b0, 1'b1, 1'b0, 16'd0};

    v_chime[0]  = '{24'h145959, 16'h0730, 1'b0, 1'b0, 1'b0, 16'd0};
    v_chime[1]  = '{24'h150000, 16'h0730, 1'b0, 1'b0, 1'b0, 16'd0};
    v_chime[2]  = '{24'h150000, 16'h0730, 1'b0, 1'b0, 1'b1, 16'd3};
    v_chime[3]  = '{24'h150000, 16'h0730, 1'b0, 1'b0, 1'b0, 16'd3};
    v_chime[4]  = '{24'h235959, 16'h0730, 1'b0, 1'b0, 1'b0, 16'd3};
    v_chime[5]  = '{24'h000000, 16'h0730, 1'b0, 1'b0, 1'b0, 16'd3};
    v_chime[6]  = '{24'h000000, 16'h0730, 1'b0, 1'b0, 1'b1, 16'd12};
    v_chime[7]  = '{24'h125959, 16'h0730, 1'b0, 1'b0, 1'b0, 16'd12};
    v_chime[8]  = '{24'h130000, 16'h0730, 1'b0, 1'b0, 1'b0, 16'd12};
    v_chime[9]  = '{24'h130000, 16'h0730, 1'b0, 1'b0, 1'b1, 16'd1};
    v_chime[10] = '{24'h130000, 16'h0730, 1'b0, 1'b0, 1'b0, 16'd1};
    v_chime[11] = '{24'h145959, 16'h1500, 1'b0, 1'b0, 1'b0, 16'd1};
    v_chime[12] = '{24'h150000, 16'h1500, 1'b0, 1'b0, 1'b0, 16'd1};
    v_chime[13] = '{24'h150000, 16'h1500, 1'b1, 1'b1, 1'b0, 16'd1};
    v_chime[14] = '{24'h150000, 16'h1500, 1'b0, 1'b1, 1'b0, 16'd1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst.ce",   32'(bus.clock_en),       32'd0);
    chk("rst.ring", 32'(ringing),            32'd0);
    chk("rst.beep", 32'(bus.beep_flag),      32'd0);
    chk("rst.max",  32'(bus.max_beep_times), 32'd0);
    rst       = 1'b0;
    alarm_arm = 1'b1;

    // match and first request
    for (int i = 0; i < 4; i++) run_vec($sformatf("main[%0d]", i), v_main[i]);

    // held match must not retrigger; then repeats with ack
    count_ce(500, c);
    chk("hold_quiet", 32'(c), 32'd0);
    ack_expect("rep2", 1'b1);
    count_ce(100, c);
    chk("rep2_quiet", 32'(c), 32'd0);
    ack_expect("rep3", 1'b1);
    count_ce(100, c);
    chk("rep3_quiet", 32'(c), 32'd0);
    ack_expect("rep_lock", 1'b0);
    count_ce(20, c);
    chk("lock_quiet", 32'(c), 32'd0);

    // lockout releases on minute change; a fresh 07:30:00 fires again
    now_time = 24'h073100;
    count_ce(3, c);
    chk("lock_exit_quiet", 32'(c), 32'd0);
    now_time = 24'h073000;
    tick();
    chk("retrig.t1", 32'(bus.clock_en), 32'd0);
    tick();
    chk("retrig.ce", 32'(bus.clock_en), 32'd1);

    // snooze for 5 minute ticks
    tick();
    press(KEY_SNOOZE);
    chk("snz.ring", 32'(ringing),      32'd1);
    chk("snz.ce",   32'(bus.clock_en), 32'd0);
    for (int m = 1; m <= 5; m++) begin
      now_time = {8'h07, 8'h30 + 8'(m), 8'h00};
      tick();
      if (m < 5) begin
        chk($sformatf("snz_tick%0d", m), 32'(bus.clock_en), 32'd0);
        count_ce(3, c);
        chk($sformatf("snz_gap%0d", m), 32'(c), 32'd0);
      end else begin
        chk("snz_fire", 32'(bus.clock_en), 32'd1);
      end
    end
    count_ce(20, c);
    chk("snz_q1", 32'(c), 32'd0);
    ack_expect("snz_rep2", 1'b1);
    count_ce(20, c);
    chk("snz_q2", 32'(c), 32'd0);
    ack_expect("snz_rep3", 1'b1);
    count_ce(20, c);
    chk("snz_q3", 32'(c), 32'd0);
    ack_expect("snz_lock", 1'b0);
    count_ce(2, c);
    chk("snz_lock_quiet", 32'(c), 32'd0);

    // cancel together with ack
    now_time = 24'h073000;
    tick();
    chk("can.t1", 32'(bus.clock_en), 32'd0);
    tick();
    chk("can_fire", 32'(bus.clock_en), 32'd1);
    tick();
    key_valid     = 1'b1;
    key_value     = KEY_CANCEL;
    bus.clock_ack = 1'b1;
    tick();
    key_valid     = 1'b0;
    bus.clock_ack = 1'b0;
    chk("can.ring", 32'(ringing), 32'd0);
    count_ce(50, c);
    chk("can_quiet", 32'(c), 32'd0);
    chk("can.ring2", 32'(ringing), 32'd0);

    // disarm during snooze
    now_time = 24'h073100;
    count_ce(2, c);
    chk("dis_pre_quiet", 32'(c), 32'd0);
    now_time = 24'h073000;
    tick();
    tick();
    chk("dis_fire", 32'(bus.clock_en), 32'd1);
    tick();
    press(KEY_SNOOZE);
    chk("dis.snz_ring", 32'(ringing), 32'd1);
    alarm_arm = 1'b0;
    tick();
    chk("dis.ring", 32'(ringing), 32'd0);
    now_time = 24'h073100;
    tick();
    alarm_arm = 1'b1;
    c = 0;
    for (int m = 2; m <= 6; m++) begin
      now_time = {8'h07, 8'h30 + 8'(m), 8'h00};
      count_ce(3, n);
      c = c + n;
    end
    chk("dis_idle_quiet", 32'(c), 32'd0);
    chk("dis_idle_ring", 32'(ringing), 32'd0);

    // ack timeout: next request 1001 cycles after the previous one
    now_time = 24'h073000;
    tick();
    chk("to.t1", 32'(bus.clock_en), 32'd0);
    tick();
    chk("to_fire", 32'(bus.clock_en), 32'd1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.clock_en && n < 1100);
    chk("to_gap", 32'(n), 32'd1001);
    press(KEY_CANCEL);
    chk("to_cancel_ring", 32'(ringing), 32'd0);

    // hourly chime and alarm-over-chime priority
    for (int i = 0; i < 15; i++) run_vec($sformatf("chime[%0d]", i), v_chime[i]);

    // async reset mid-song
    press(KEY_CANCEL);
    now_time = 24'h150100;
    tick();
    now_time = 24'h150000;
    tick();
    tick();
    chk("rst_pre.ce", 32'(bus.clock_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid.ce",   32'(bus.clock_en),       32'd0);
    chk("rst_mid.ring", 32'(ringing),            32'd0);
    chk("rst_mid.max",  32'(bus.max_beep_times), 32'd0);
    tick();
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_sched.md
# alarm_sched

Alarm and hourly-chime scheduler sitting between the DS1302 time readout and the buzzer block. Compares the live BCD time against a programmed alarm time and starts a song via the `clock_en`/`clock_ack` handshake, with repeat, snooze and cancel handling. Optionally issues a one-cycle `beep_flag` on each hour rollover, with a beep count equal to the hour.

## Interface
- `RING_REPEAT`, 3: song plays per alarm event, range 1..15.
- `SNOOZE_MIN`, 5: snooze length in minute ticks, range 1..59.
- `ACK_TIMEOUT`, 480_000_000: cycles to wait for song completion before forcing the next step (20 s at 24 MHz); counter width 29 bits.
- `clk` in 1: 24 MHz system clock.
- `rst` in 1: asynchronous, active-high reset.
- `now_time` in 24: BCD hh:mm:ss, 24 h, from the RTC reader; may change on any cycle.
- `alarm_time` in 16: BCD hh:mm, 24 h.
- `alarm_arm` in 1: level; alarm is enabled while high.
- `key_valid` in 1: one-cycle key strobe.
- `key_value` in 4: key code; 4'd11 = snooze, 4'd0 = cancel.
- `clock_ack` in 1: from the buzzer; rises when a song ends or is stopped.
- `clock_en` out 1: one-cycle song start request.
- `beep_flag` out 1: one-cycle chime start pulse.
- `max_beep_times` out 16: chime beep count, valid from `beep_flag` until the next chime.
- `ringing` out 1: high in START, PLAY and SNOOZE.

## Operation
- Match condition: `alarm_arm` & `now_time[23:8]==alarm_time` & `now_time[7:0]==8'h00`. The alarm fires on the rising edge of the registered match, so one minute of equality gives one event.
- Minute tick: a one-cycle pulse when `now_time[15:8]` differs from its registered copy.
- `clock_ack` is double-registered. Only its rising edge is used (`ack_rise`).
- Every state goes to IDLE on `alarm_arm`==0. In that case `clock_en` is not asserted and the counters clear.
- FSM states and transitions:
  - IDLE: on match edge → START, with rep_cnt=0.
  - START: `clock_en`=1 for exactly this cycle. Clears to_cnt, then → PLAY.
  - PLAY: waits for `ack_rise` or to_cnt==ACK_TIMEOUT-1. Then rep_cnt+1. If rep_cnt+1==RING_REPEAT → LOCKOUT, else → START.
  - SNOOZE: counts minute ticks in snz_cnt. At snz_cnt==SNOOZE_MIN → START, with rep_cnt=0.
  - LOCKOUT: waits until `now_time[15:8]` differs from `alarm_time[7:0]` (or the hour differs), then → IDLE. This blocks re-trigger within the same minute.
- Keys in PLAY or START:
  - Snooze → SNOOZE, snz_cnt=0.
  - Cancel → LOCKOUT.
  - Key 0 also stops the buzzer, so the resulting `ack_rise` in LOCKOUT is ignored.
- Keys in SNOOZE: cancel → LOCKOUT; snooze is ignored.
- Keys in IDLE or LOCKOUT: ignored.
- Priority within one cycle: disarm > cancel > snooze > `ack_rise` > timeout.
- Arithmetic: rep_cnt is 4 bits, snz_cnt 6 bits, to_cnt 29 bits. None wraps; each saturates at its terminal compare.

## Timing
- Reset values: `clock_en`=0, `beep_flag`=0, `max_beep_times`=16'd0, `ringing`=0, FSM=IDLE, all counters 0, registered time copies 0.
- Match-to-`clock_en` latency: 2 cycles after `now_time` presents hh:mm:00 (register, then edge, then START output).
- `clock_ack` edge to next START: 3 cycles (2 synchroniser stages plus the FSM step).
- `clock_en` is never high on two consecutive cycles. The minimum gap between requests is 2 cycles.
- `rst` mid-song: `clock_en` drops asynchronously. The buzzer's own reset clears it independently.

## Configuration
- `ALARM_SCHED_CHIME_EN` defined:
  - On the first cycle where `now_time[15:0]`==16'h0000 and the previous registered value differs, and the FSM is in IDLE or LOCKOUT, `beep_flag` pulses for 1 cycle.
  - `max_beep_times` is set to the binary 12 h hour: 00→12, 13→1, 12→12.
  - When the chime coincides with an alarm match edge, the alarm wins and the chime is dropped.
- Not defined: `beep_flag` is tied to 0, `max_beep_times` is tied to 0, and no chime logic is generated.

## Structure
- Package `alarm_pkg`:
  - FSM state enum: IDLE, START, PLAY, SNOOZE, LOCKOUT.
  - Key codes: KEY_SNOOZE=4'd11, KEY_CANCEL=4'd0.
  - Function `bcd_hour_to_12h(input [7:0])` returning a 16-bit count.
- Sub-module `time_tick_det`: registers `now_time`, produces the minute-tick and hour-rollover pulses, and the match edge.

## Test plan
- Armed, alarm 07:30; `now_time` steps 07:29:59 → 07:30:00 → `clock_en` pulses once 2 cycles later and `ringing`=1. Holding 07:30:00 for 1000 cycles produces no further pulse.
- RING_REPEAT=3; return a `clock_ack` pulse 100 cycles after each `clock_en` → exactly 3 `clock_en` pulses, then LOCKOUT. At 07:31:00 → IDLE, with no re-trigger.
- During PLAY, snooze key; apply 5 minute changes → `clock_en` on the 5th tick +1 cycle, rep_cnt restarted; 3 more plays follow.
- During PLAY, cancel key together with `clock_ack` → no further `clock_en`, `ringing`=0. Drop `alarm_arm` during SNOOZE → IDLE immediately.
- No ack for ACK_TIMEOUT (override to 1000) cycles → next `clock_en` 1 cycle after the timeout.
- With CHIME_EN: 14:59:59 → 15:00:00 gives a `beep_flag` pulse and `max_beep_times`=3. With alarm 15:00 armed, the same step gives `clock_en` only and no `beep_flag`. Without the macro, `beep_flag` stays 0.
